// File: rtl/led_arb_pkg.sv
// Shared types and helpers for the LED frame arbiter.
package led_arb_pkg;

  // Arbiter frame sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    STREAM = 2'd2,
    LATCH  = 2'd3
  } arb_state_t;

  // Which source owns the current frame.
  typedef enum logic {
    SRC_DISPLAY = 1'b0,
    SRC_CALIB   = 1'b1
  } arb_source_t;

  // Upper bounds for the helper's operands; callers size-cast into and out of these.
  localparam int ADDR_MAX_W  = 16;
  localparam int SEL_MAX_W   = 4;
  localparam int COLOR_MAX_W = 32;

  // LEDs whose selected address bit is set light up in on_color, all others stay black.
  function automatic logic [COLOR_MAX_W-1:0] calib_pattern_color(
    input logic [ADDR_MAX_W-1:0]  addr,
    input logic [SEL_MAX_W-1:0]   bit_sel,
    input logic [COLOR_MAX_W-1:0] on_color
  );
    return addr[bit_sel] ? on_color : {COLOR_MAX_W{1'b0}};
  endfunction

endpackage

// File: rtl/led_frame_arbiter_if.sv
// Signal bundle between the arbiter (master) and its sources/strand driver (slave).
interface led_frame_arbiter_if #(
  parameter int LED_ADDRESS_WIDTH      = 6,
  parameter int LED_ADDR_BIT_SEL_WIDTH = 3,
  parameter int COLOR_WIDTH            = 24
);
  logic                              display_enable_in;
  logic [COLOR_WIDTH-1:0]            display_color_in;
  logic                              calib_start_in;
  logic [LED_ADDR_BIT_SEL_WIDTH-1:0] calib_bit_sel_in;
  logic                              driver_pixel_req_in;
  logic                              strip_start_out;
  logic [LED_ADDRESS_WIDTH-1:0]      pixel_addr_out;
  logic [COLOR_WIDTH-1:0]            pixel_color_out;
  logic                              pixel_valid_out;
  logic                              grant_calib_out;
  logic                              frame_done_out;
  logic                              led_display_valid_out;

  modport master (
    input  display_enable_in, display_color_in, calib_start_in, calib_bit_sel_in,
           driver_pixel_req_in,
    output strip_start_out, pixel_addr_out, pixel_color_out, pixel_valid_out,
           grant_calib_out, frame_done_out, led_display_valid_out
  );

  modport slave (
    output display_enable_in, display_color_in, calib_start_in, calib_bit_sel_in,
           driver_pixel_req_in,
    input  strip_start_out, pixel_addr_out, pixel_color_out, pixel_valid_out,
           grant_calib_out, frame_done_out, led_display_valid_out
  );
endinterface

// File: rtl/led_latch_timer.sv
// Down-counter that times the strand latch gap after the last pixel of a frame.
module led_latch_timer #(
  parameter int LATCH_CYCLES = 5000,
  localparam int TW = $clog2(LATCH_CYCLES)
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic i_load,
  output logic o_zero
);
  logic [TW-1:0] r_count;

  // Load the full gap on entry, then count down to zero and rest there.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_count <= {TW{1'b0}};
    end else if (i_load) begin
      r_count <= TW'(LATCH_CYCLES - 1);
    end else if (r_count != {TW{1'b0}}) begin
      r_count <= r_count - TW'(1);
    end
  end

  assign o_zero = (r_count == {TW{1'b0}});
endmodule

// File: rtl/led_frame_arbiter.sv
// Shares one WS2812 strand driver between the display source and the calibration
// pattern, granting whole frames with calibration taking priority.
module led_frame_arbiter
  import led_arb_pkg::*;
#(
  parameter int NUM_LEDS               = 50,
  parameter int LED_ADDRESS_WIDTH      = $clog2(NUM_LEDS),
  parameter int LED_ADDR_BIT_SEL_WIDTH = $clog2(LED_ADDRESS_WIDTH),
  parameter int COLOR_WIDTH            = 24,
  parameter int LATCH_CYCLES           = 5000,
  parameter logic [COLOR_WIDTH-1:0] CALIB_ON_COLOR = 24'hFFFFFF
) (
  input logic               clk_in,
  input logic               rst_in,
  led_frame_arbiter_if.master arb_bus
);
  localparam int AW = LED_ADDRESS_WIDTH;
  localparam int SW = LED_ADDR_BIT_SEL_WIDTH;

  arb_state_t             r_state;
  arb_state_t             w_state_next;
  arb_source_t            r_src;
  logic                   r_calib_pending;
  logic [SW-1:0]          r_bit_sel_q;
  logic [SW-1:0]          r_frame_sel;
  logic [AW-1:0]          r_addr;
  logic [AW:0]            w_addr_inc;
  logic                   w_take_req;
  logic                   w_load;
  logic                   w_exit;
  logic                   w_latch_zero;
  logic                   r_strip_start;
  logic                   r_pixel_valid;
  logic [COLOR_WIDTH-1:0] r_pixel_color;
  logic [COLOR_WIDTH-1:0] w_pixel_color;
  logic                   r_grant_calib;
  logic                   r_frame_done;
  logic                   r_led_valid;

  // One extra bit so the last-pixel compare works even when NUM_LEDS is a power of two.
  assign w_addr_inc = {1'b0, r_addr} + {{AW{1'b0}}, 1'b1};

  led_latch_timer #(.LATCH_CYCLES(LATCH_CYCLES)) u_latch_timer (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .i_load (w_load),
    .o_zero (w_latch_zero)
  );

  // Colour for the pixel currently addressed, from the frame's owner.
  always_comb begin
    if (r_grant_calib) begin
      w_pixel_color = COLOR_WIDTH'(calib_pattern_color(ADDR_MAX_W'(r_addr),
                                                       SEL_MAX_W'(r_frame_sel),
                                                       COLOR_MAX_W'(CALIB_ON_COLOR)));
    end else begin
      w_pixel_color = arb_bus.display_color_in;
    end
  end

  // Frame sequencing: next state and per-cycle control strobes.
  always_comb begin
    w_state_next = r_state;
    w_take_req   = 1'b0;
    w_load       = 1'b0;
    w_exit       = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_calib_pending || arb_bus.display_enable_in) begin
          w_state_next = GRANT;
        end else begin
          w_state_next = IDLE;
        end
      end
      GRANT: begin
        w_state_next = STREAM;
      end
      STREAM: begin
        if (arb_bus.driver_pixel_req_in) begin
          w_take_req = 1'b1;
          if (w_addr_inc == (AW + 1)'(NUM_LEDS)) begin
            w_load       = 1'b1;
            w_state_next = LATCH;
          end else begin
            w_state_next = STREAM;
          end
        end else begin
          w_state_next = STREAM;
        end
      end
      LATCH: begin
        if (w_latch_zero) begin
          w_exit       = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_state_next = LATCH;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Pending calibration request, frame ownership, address and registered outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_calib_pending <= 1'b0;
      r_bit_sel_q     <= {SW{1'b0}};
      r_frame_sel     <= {SW{1'b0}};
      r_src           <= SRC_DISPLAY;
      r_addr          <= {AW{1'b0}};
      r_strip_start   <= 1'b0;
      r_pixel_valid   <= 1'b0;
      r_pixel_color   <= {COLOR_WIDTH{1'b0}};
      r_grant_calib   <= 1'b0;
      r_frame_done    <= 1'b0;
      r_led_valid     <= 1'b0;
    end else begin
      // A fresh start request wins over the clear so a request landing on GRANT survives.
      if (arb_bus.calib_start_in) begin
        r_calib_pending <= 1'b1;
        r_bit_sel_q     <= arb_bus.calib_bit_sel_in;
      end else if ((r_state == GRANT) && (r_src == SRC_CALIB)) begin
        r_calib_pending <= 1'b0;
      end
      if ((r_state == IDLE) && (w_state_next == GRANT)) begin
        r_src <= r_calib_pending ? SRC_CALIB : SRC_DISPLAY;
      end
      r_strip_start <= (r_state == IDLE) && (w_state_next == GRANT);
      // The bit select is frozen here so later start pulses cannot disturb this frame.
      if (r_state == GRANT) begin
        r_addr        <= {AW{1'b0}};
        r_grant_calib <= (r_src == SRC_CALIB);
        r_frame_sel   <= r_bit_sel_q;
      end else if (w_take_req && !w_load) begin
        r_addr <= w_addr_inc[AW-1:0];
      end
      r_pixel_valid <= w_take_req;
      if (w_take_req) begin
        r_pixel_color <= w_pixel_color;
      end
      r_frame_done <= w_exit;
      r_led_valid  <= w_exit && r_grant_calib;
    end
  end

  assign arb_bus.strip_start_out       = r_strip_start;
  assign arb_bus.pixel_addr_out        = r_addr;
  assign arb_bus.pixel_color_out       = r_pixel_color;
  assign arb_bus.pixel_valid_out       = r_pixel_valid;
  assign arb_bus.grant_calib_out       = r_grant_calib;
  assign arb_bus.frame_done_out        = r_frame_done;
  assign arb_bus.led_display_valid_out = r_led_valid;
endmodule

// File: tb/tb_led_frame_arbiter.sv
// Self-checking bench for led_frame_arbiter on an 8-LED strand with a 4-cycle latch gap.
module tb_led_frame_arbiter;
  localparam int NL = 8;
  localparam int LC = 4;
  localparam int AW = 3;
  localparam int SW = 2;
  localparam int CW = 24;
  localparam logic [CW-1:0] ON = 24'hFFFFFF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  led_frame_arbiter_if #(.LED_ADDRESS_WIDTH(AW), .LED_ADDR_BIT_SEL_WIDTH(SW), .COLOR_WIDTH(CW)) bus ();

  led_frame_arbiter #(
    .NUM_LEDS(NL), .LED_ADDRESS_WIDTH(AW), .LED_ADDR_BIT_SEL_WIDTH(SW),
    .COLOR_WIDTH(CW), .LATCH_CYCLES(LC), .CALIB_ON_COLOR(ON)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .arb_bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc, n_starts, n_done, n_ldv, n_valid, last_valid_cyc, last_done_cyc;
  logic [CW-1:0] pix_q[$];
  bit            done_src_q[$];
  int            done_gap_q[$];
  int            start_gap_q[$];
  logic [CW-1:0] lut[NL];
  bit            ph;

  // Reference: what pixel idx of a frame must look like.
  function automatic logic [CW-1:0] model_color(bit calib, int sel, int idx);
    if (calib) return (((idx >> sel) & 1) != 0) ? ON : 24'h000000;
    return lut[idx];
  endfunction

  function automatic logic [CW-1:0] got_pix(int idx);
    return (idx < pix_q.size()) ? pix_q[idx] : {CW{1'bx}};
  endfunction

  task automatic clear_log();
    cyc = 0; n_starts = 0; n_done = 0; n_ldv = 0; n_valid = 0;
    last_valid_cyc = 0; last_done_cyc = 0;
    pix_q.delete(); done_src_q.delete(); done_gap_q.delete(); start_gap_q.delete();
  endtask

  // One clock: apply req, sample outputs just after the edge, log events.
  task automatic step(input bit req);
    bus.driver_pixel_req_in = req;
    @(posedge clk);
    #1;
    bus.calib_start_in      = 1'b0;
    bus.driver_pixel_req_in = 1'b0;
    cyc++;
    if (bus.strip_start_out) begin n_starts++; start_gap_q.push_back(cyc - last_done_cyc); end
    if (bus.pixel_valid_out) begin n_valid++; pix_q.push_back(bus.pixel_color_out); last_valid_cyc = cyc; end
    if (bus.frame_done_out) begin
      n_done++; done_src_q.push_back(bus.grant_calib_out);
      done_gap_q.push_back(cyc - last_valid_cyc); last_done_cyc = cyc;
    end
    if (bus.led_display_valid_out) n_ldv++;
    bus.display_color_in = lut[bus.pixel_addr_out];
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    bus.display_enable_in = 1'b0; bus.calib_start_in = 1'b0;
    bus.calib_bit_sel_in = 2'd0; bus.driver_pixel_req_in = 1'b0;
    bus.display_color_in = lut[0];
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_log();
  endtask

  task automatic test_reset();
    bus.display_enable_in = 1'b0; bus.calib_start_in = 1'b0;
    bus.calib_bit_sel_in = 2'd0; bus.driver_pixel_req_in = 1'b0;
    bus.display_color_in = 24'h0;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus.strip_start_out !== 1'b0) $display("FAIL rst_strip_start: got %b expected 0", bus.strip_start_out); else n_pass++;
    n_checks++; if (bus.pixel_addr_out !== 3'd0) $display("FAIL rst_addr: got %0d expected 0", bus.pixel_addr_out); else n_pass++;
    n_checks++; if (bus.pixel_color_out !== 24'h0) $display("FAIL rst_color: got %h expected 0", bus.pixel_color_out); else n_pass++;
    n_checks++; if (bus.pixel_valid_out !== 1'b0) $display("FAIL rst_valid: got %b expected 0", bus.pixel_valid_out); else n_pass++;
    n_checks++; if (bus.grant_calib_out !== 1'b0) $display("FAIL rst_grant: got %b expected 0", bus.grant_calib_out); else n_pass++;
    n_checks++; if (bus.frame_done_out !== 1'b0) $display("FAIL rst_done: got %b expected 0", bus.frame_done_out); else n_pass++;
    n_checks++; if (bus.led_display_valid_out !== 1'b0) $display("FAIL rst_ldv: got %b expected 0", bus.led_display_valid_out); else n_pass++;
  endtask

  task automatic test_display_frames();
    reset_dut();
    bus.display_enable_in = 1'b1;
    ph = 1'b0;
    for (int k = 0; k < 300 && n_starts < 2; k++) begin step(ph); ph = !ph; end
    bus.display_enable_in = 1'b0;
    for (int k = 0; k < 300 && n_done < 2; k++) begin step(ph); ph = !ph; end
    repeat (20) begin step(ph); ph = !ph; end
    n_checks++; if (n_starts !== 2) $display("FAIL disp_starts: got %0d expected 2", n_starts); else n_pass++;
    n_checks++; if (n_done !== 2) $display("FAIL disp_done: got %0d expected 2", n_done); else n_pass++;
    n_checks++; if (n_valid !== 2 * NL) $display("FAIL disp_valids: got %0d expected %0d", n_valid, 2 * NL); else n_pass++;
    for (int i = 0; i < 2 * NL; i++) begin
      n_checks++;
      if (got_pix(i) !== model_color(1'b0, 0, i % NL)) $display("FAIL disp_pix%0d: got %h expected %h", i, got_pix(i), model_color(1'b0, 0, i % NL));
      else n_pass++;
    end
    n_checks++; if (done_src_q.size() < 1 || done_src_q[0] !== 1'b0) $display("FAIL disp_src: got calib frame expected display"); else n_pass++;
    n_checks++; if (done_gap_q.size() < 1 || done_gap_q[0] !== LC) $display("FAIL disp_latch_gap: got %0d expected %0d", (done_gap_q.size() > 0) ? done_gap_q[0] : -1, LC); else n_pass++;
    n_checks++; if (start_gap_q.size() < 2 || start_gap_q[1] !== 1) $display("FAIL disp_restart_gap: got %0d expected 1", (start_gap_q.size() > 1) ? start_gap_q[1] : -1); else n_pass++;
    n_checks++; if (n_ldv !== 0) $display("FAIL disp_ldv: got %0d expected 0", n_ldv); else n_pass++;
  endtask

  task automatic test_calib_frame();
    reset_dut();
    bus.calib_start_in = 1'b1; bus.calib_bit_sel_in = 2'd1;
    step(1'b0);
    for (int k = 0; k < 400 && n_done < 1; k++) step(1'($urandom_range(0, 1)));
    repeat (20) step(1'($urandom_range(0, 1)));
    for (int i = 0; i < NL; i++) begin
      n_checks++;
      if (got_pix(i) !== model_color(1'b1, 1, i)) $display("FAIL cal_pix%0d: got %h expected %h", i, got_pix(i), model_color(1'b1, 1, i));
      else n_pass++;
    end
    n_checks++; if (n_starts !== 1) $display("FAIL cal_starts: got %0d expected 1", n_starts); else n_pass++;
    n_checks++; if (n_ldv !== 1) $display("FAIL cal_ldv: got %0d expected 1", n_ldv); else n_pass++;
    n_checks++; if (done_src_q.size() < 1 || done_src_q[0] !== 1'b1) $display("FAIL cal_src: got display frame expected calib"); else n_pass++;
    n_checks++; if (done_gap_q.size() < 1 || done_gap_q[0] !== LC) $display("FAIL cal_latch_gap: got %0d expected %0d", (done_gap_q.size() > 0) ? done_gap_q[0] : -1, LC); else n_pass++;
  endtask

  task automatic test_calib_preempt();
    reset_dut();
    for (int i = 0; i < NL; i++) lut[i] = 24'($urandom);
    bus.display_color_in = lut[0];
    bus.display_enable_in = 1'b1;
    ph = 1'b0;
    for (int k = 0; k < 300 && pix_q.size() < 3; k++) begin step(ph); ph = !ph; end
    bus.calib_start_in = 1'b1; bus.calib_bit_sel_in = 2'd2;
    step(ph); ph = !ph;
    for (int k = 0; k < 300 && n_starts < 2; k++) begin step(ph); ph = !ph; end
    bus.display_enable_in = 1'b0;
    for (int k = 0; k < 300 && n_done < 2; k++) begin step(ph); ph = !ph; end
    repeat (20) begin step(ph); ph = !ph; end
    for (int i = 0; i < NL; i++) begin
      n_checks++;
      if (got_pix(i) !== model_color(1'b0, 0, i)) $display("FAIL pre_disp_pix%0d: got %h expected %h", i, got_pix(i), model_color(1'b0, 0, i));
      else n_pass++;
      n_checks++;
      if (got_pix(NL + i) !== model_color(1'b1, 2, i)) $display("FAIL pre_cal_pix%0d: got %h expected %h", i, got_pix(NL + i), model_color(1'b1, 2, i));
      else n_pass++;
    end
    n_checks++; if (done_src_q.size() < 2 || done_src_q[0] !== 1'b0 || done_src_q[1] !== 1'b1) $display("FAIL pre_order: got %0d frames, expected display then calib", done_src_q.size()); else n_pass++;
    n_checks++; if (n_ldv !== 1) $display("FAIL pre_ldv: got %0d expected 1", n_ldv); else n_pass++;
    n_checks++; if (n_starts !== 2) $display("FAIL pre_starts: got %0d expected 2", n_starts); else n_pass++;
  endtask

  task automatic test_calib_requeue();
    reset_dut();
    bus.calib_start_in = 1'b1; bus.calib_bit_sel_in = 2'd1;
    step(1'b0);
    for (int k = 0; k < 300 && pix_q.size() < 2; k++) step(1'($urandom_range(0, 1)));
    bus.calib_start_in = 1'b1; bus.calib_bit_sel_in = 2'd0;
    step(1'($urandom_range(0, 1)));
    for (int k = 0; k < 400 && n_done < 2; k++) step(1'($urandom_range(0, 1)));
    repeat (20) step(1'($urandom_range(0, 1)));
    for (int i = 0; i < NL; i++) begin
      n_checks++;
      if (got_pix(i) !== model_color(1'b1, 1, i)) $display("FAIL rq_first_pix%0d: got %h expected %h", i, got_pix(i), model_color(1'b1, 1, i));
      else n_pass++;
      n_checks++;
      if (got_pix(NL + i) !== model_color(1'b1, 0, i)) $display("FAIL rq_second_pix%0d: got %h expected %h", i, got_pix(NL + i), model_color(1'b1, 0, i));
      else n_pass++;
    end
    n_checks++; if (n_ldv !== 2) $display("FAIL rq_ldv: got %0d expected 2", n_ldv); else n_pass++;
    n_checks++; if (n_starts !== 2) $display("FAIL rq_starts: got %0d expected 2", n_starts); else n_pass++;
    n_checks++; if (start_gap_q.size() < 2 || start_gap_q[1] !== 1) $display("FAIL rq_restart_gap: got %0d expected 1", (start_gap_q.size() > 1) ? start_gap_q[1] : -1); else n_pass++;
  endtask

  task automatic test_ignored_reqs();
    int sel;
    reset_dut();
    sel = int'($urandom_range(0, 3));
    repeat (10) step(1'b1);
    n_checks++; if (n_valid !== 0) $display("FAIL ign_idle_valid: got %0d expected 0", n_valid); else n_pass++;
    n_checks++; if (bus.pixel_addr_out !== 3'd0) $display("FAIL ign_idle_addr: got %0d expected 0", bus.pixel_addr_out); else n_pass++;
    bus.calib_start_in = 1'b1; bus.calib_bit_sel_in = 2'(sel);
    step(1'b1);
    for (int k = 0; k < 300 && n_done < 1; k++) step(1'b1);
    repeat (10) step(1'b1);
    n_checks++; if (n_valid !== NL) $display("FAIL ign_valids: got %0d expected %0d", n_valid, NL); else n_pass++;
    n_checks++; if (n_starts !== 1) $display("FAIL ign_starts: got %0d expected 1", n_starts); else n_pass++;
    n_checks++; if (bus.pixel_addr_out !== 3'(NL - 1)) $display("FAIL ign_addr_hold: got %0d expected %0d", bus.pixel_addr_out, NL - 1); else n_pass++;
    n_checks++; if (done_gap_q.size() < 1 || done_gap_q[0] !== LC) $display("FAIL ign_latch_gap: got %0d expected %0d", (done_gap_q.size() > 0) ? done_gap_q[0] : -1, LC); else n_pass++;
    for (int i = 0; i < NL; i++) begin
      n_checks++;
      if (got_pix(i) !== model_color(1'b1, sel, i)) $display("FAIL ign_pix%0d: got %h expected %h", i, got_pix(i), model_color(1'b1, sel, i));
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_stream();
    reset_dut();
    bus.display_enable_in = 1'b1;
    ph = 1'b0;
    for (int k = 0; k < 300 && pix_q.size() < 2; k++) begin step(ph); ph = !ph; end
    bus.calib_start_in = 1'b1; bus.calib_bit_sel_in = 2'd1;
    step(ph); ph = !ph;
    for (int k = 0; k < 300 && pix_q.size() < 4; k++) begin step(ph); ph = !ph; end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus.pixel_addr_out !== 3'd0) $display("FAIL mid_rst_addr: got %0d expected 0", bus.pixel_addr_out); else n_pass++;
    n_checks++; if (bus.pixel_color_out !== 24'h0) $display("FAIL mid_rst_color: got %h expected 0", bus.pixel_color_out); else n_pass++;
    n_checks++; if (bus.pixel_valid_out !== 1'b0) $display("FAIL mid_rst_valid: got %b expected 0", bus.pixel_valid_out); else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_log();
    bus.display_enable_in = 1'b0;
    repeat (30) begin step(ph); ph = !ph; end
    n_checks++; if (n_starts !== 0) $display("FAIL mid_rst_starts: got %0d expected 0", n_starts); else n_pass++;
    n_checks++; if (n_done !== 0) $display("FAIL mid_rst_done: got %0d expected 0", n_done); else n_pass++;
    n_checks++; if (n_ldv !== 0) $display("FAIL mid_rst_ldv: got %0d expected 0", n_ldv); else n_pass++;
    n_checks++; if (n_valid !== 0) $display("FAIL mid_rst_valid_count: got %0d expected 0", n_valid); else n_pass++;
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < NL; i++) lut[i] = 24'(i * 3);
    test_reset();
    test_display_frames();
    for (int i = 0; i < NL; i++) lut[i] = 24'($urandom);
    test_display_frames();
    test_calib_frame();
    test_calib_preempt();
    test_calib_requeue();
    test_ignored_reqs();
    test_reset_mid_stream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
